reg_scoreboard: RTL and testbench

Hazard scoreboard for the 8-entry, 16-bit register file. It tracks every in-flight register write from issue to writeback and drives the per-register `register_invalid` codes that the register file consumes for writeback-stage bypass. It also raises `stall` when a source operand is pending and cannot be bypassed. It sits beside the decode stage, fed by decode and by the pipeline advance and flush controls.

---
 rtl/reg_scoreboard.sv | 76 +++++++
 tb/tb_reg_scoreboard.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard.sv
// Hazard scoreboard for the 8-entry register file: tracks in-flight writes per
// register, drives the youngest-pending bypass codes and stalls unresolvable reads.
module reg_scoreboard #(
  parameter int NREG   = 8,
  parameter int STAGES = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      adv,
  input  logic                      flush,
  input  logic                      issue_valid,
  input  logic                      issue_we,
  input  logic [$clog2(NREG)-1:0]   issue_wr,
  input  logic [$clog2(NREG)-1:0]   issue_rs1,
  input  logic [$clog2(NREG)-1:0]   issue_rs2,
  input  logic                      issue_use1,
  input  logic                      issue_use2,
  output logic [NREG-1:0][2:0]      register_invalid,
  output logic                      stall,
  output logic                      issue_ack,
  output logic                      busy
);

  localparam int IW = $clog2(NREG);
  // Flush squashes the two youngest slots; older ones keep flowing to writeback.
  localparam logic [STAGES-1:0] SQUASH = STAGES'(2'b11);

  logic [NREG-1:0][STAGES-1:0] pend;
  logic [NREG-1:0][STAGES-1:0] pend_next;
  logic [STAGES-1:0]           keep;

  // Youngest pending slot wins; the code mapping assumes STAGES == 4.
  function automatic logic [2:0] code_of(input logic [STAGES-1:0] p);
    if (p[0])      return 3'd7;
    else if (p[1]) return 3'd6;
    else if (p[2]) return 3'd5;
    else if (p[3]) return 3'd4;
    else           return 3'd0;
  endfunction

  // Code 4 is served by the writeback bypass, so only 5..7 block a reader.
  function automatic logic in_flight(input logic [2:0] c);
    return c inside {3'd5, 3'd6, 3'd7};
  endfunction

  always_comb begin
    for (int r = 0; r < NREG; r++) register_invalid[r] = code_of(pend[r]);
  end

  assign stall = issue_valid &
                 ((issue_use1 & in_flight(register_invalid[issue_rs1])) |
                  (issue_use2 & in_flight(register_invalid[issue_rs2])));

  assign issue_ack = issue_valid & adv & ~stall & ~flush;
  assign busy      = |pend;

  always_comb begin
    // NOTE: every variable gets a default before the loop so no path leaves it
    // unassigned and no latch is inferred.
    pend_next = pend;
    keep      = '0;
    for (int r = 0; r < NREG; r++) begin
      keep = flush ? (pend[r] & ~SQUASH) : pend[r];
      if (adv) pend_next[r] = {keep[STAGES-2:0], issue_ack & issue_we & (issue_wr == IW'(r))};
      else     pend_next[r] = keep;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update
  // together at the edge; the pending array is plain flops, so it is reset whole.
  always_ff @(posedge clk) begin
    if (reset) pend <= '0;
    else       pend <= pend_next;
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: each scenario queues per-cycle stimulus
// with its expected codes/stall/ack/busy and compares them as the DUT responds.
module tb_reg_scoreboard;

  logic             clk;
  logic             reset;
  logic             adv;
  logic             flush;
  logic             issue_valid;
  logic             issue_we;
  logic [2:0]       issue_wr;
  logic [2:0]       issue_rs1;
  logic [2:0]       issue_rs2;
  logic             issue_use1;
  logic             issue_use2;
  logic [7:0][2:0]  register_invalid;
  logic             stall;
  logic             issue_ack;
  logic             busy;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic       reset, adv, flush, valid, we;
    logic [2:0] wr, rs1;
    logic       use1;
    logic [2:0] rs2;
    logic       use2;
  } stim_t;

  typedef struct packed {
    logic [7:0][2:0] codes;
    logic            stall, ack, busy;
  } exp_t;

  exp_t exp_q[$];

  reg_scoreboard #(.NREG(8), .STAGES(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .adv              (adv),
    .flush            (flush),
    .issue_valid      (issue_valid),
    .issue_we         (issue_we),
    .issue_wr         (issue_wr),
    .issue_rs1        (issue_rs1),
    .issue_rs2        (issue_rs2),
    .issue_use1       (issue_use1),
    .issue_use2       (issue_use2),
    .register_invalid (register_invalid),
    .stall            (stall),
    .issue_ack        (issue_ack),
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t s_idle(input logic a = 1'b1);
    stim_t s = '0;
    s.adv = a;
    return s;
  endfunction

  function automatic stim_t s_write(input logic [2:0] r);
    stim_t s = s_idle();
    s.valid = 1'b1;
    s.we    = 1'b1;
    s.wr    = r;
    return s;
  endfunction

  function automatic stim_t s_read(input logic [2:0] r, input int port);
    stim_t s = s_idle();
    s.valid = 1'b1;
    if (port == 1) begin s.rs1 = r; s.use1 = 1'b1; end
    else           begin s.rs2 = r; s.use2 = 1'b1; end
    return s;
  endfunction

  // Expected code vector: up to three registers non-zero, the rest 0.
  function automatic logic [7:0][2:0] cv(input int ra = -1, input logic [2:0] ca = 0,
                                         input int rb = -1, input logic [2:0] cb = 0,
                                         input int rc = -1, input logic [2:0] cc = 0);
    logic [7:0][2:0] v = '0;
    if (ra >= 0) v[ra[2:0]] = ca;
    if (rb >= 0) v[rb[2:0]] = cb;
    if (rc >= 0) v[rc[2:0]] = cc;
    return v;
  endfunction

  function automatic exp_t ex(input logic [7:0][2:0] c, input logic s, input logic a,
                              input logic b);
    exp_t e;
    e.codes = c; e.stall = s; e.ack = a; e.busy = b;
    return e;
  endfunction

  task automatic drive(input stim_t s);
    reset       = s.reset;
    adv         = s.adv;
    flush       = s.flush;
    issue_valid = s.valid;
    issue_we    = s.we;
    issue_wr    = s.wr;
    issue_rs1   = s.rs1;
    issue_use1  = s.use1;
    issue_rs2   = s.rs2;
    issue_use2  = s.use2;
  endtask

  task automatic test_reset();
    stim_t sq[$];
    exp_t  eq[$];
    exp_t  e;
    stim_t s;
    s = s_read(3, 1); s.adv = 1'b0;
    sq.push_back(s);              eq.push_back(ex(cv(), 0, 0, 0));
    sq.push_back(s_read(3, 1));   eq.push_back(ex(cv(), 0, 1, 0));
    sq.push_back(s_idle());       eq.push_back(ex(cv(), 0, 0, 0));
    foreach (sq[i]) begin
      drive(sq[i]);
      exp_q.push_back(eq[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      checks += 4;
      if (register_invalid !== e.codes) begin errors++; $display("FAIL reset[%0d] codes: got %h expected %h", i, register_invalid, e.codes); end
      if (stall !== e.stall)            begin errors++; $display("FAIL reset[%0d] stall: got %b expected %b", i, stall, e.stall); end
      if (issue_ack !== e.ack)          begin errors++; $display("FAIL reset[%0d] issue_ack: got %b expected %b", i, issue_ack, e.ack); end
      if (busy !== e.busy)              begin errors++; $display("FAIL reset[%0d] busy: got %b expected %b", i, busy, e.busy); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_raw();
    stim_t sq[$];
    exp_t  eq[$];
    exp_t  e;
    sq.push_back(s_write(2));     eq.push_back(ex(cv(), 0, 1, 0));
    sq.push_back(s_read(2, 1));   eq.push_back(ex(cv(2, 7), 1, 0, 1));
    sq.push_back(s_read(2, 1));   eq.push_back(ex(cv(2, 6), 1, 0, 1));
    sq.push_back(s_read(2, 1));   eq.push_back(ex(cv(2, 5), 1, 0, 1));
    sq.push_back(s_read(2, 1));   eq.push_back(ex(cv(2, 4), 0, 1, 1));
    sq.push_back(s_idle());       eq.push_back(ex(cv(), 0, 0, 0));
    foreach (sq[i]) begin
      drive(sq[i]);
      exp_q.push_back(eq[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      checks += 4;
      if (register_invalid !== e.codes) begin errors++; $display("FAIL raw[%0d] codes: got %h expected %h", i, register_invalid, e.codes); end
      if (stall !== e.stall)            begin errors++; $display("FAIL raw[%0d] stall: got %b expected %b", i, stall, e.stall); end
      if (issue_ack !== e.ack)          begin errors++; $display("FAIL raw[%0d] issue_ack: got %b expected %b", i, issue_ack, e.ack); end
      if (busy !== e.busy)              begin errors++; $display("FAIL raw[%0d] busy: got %b expected %b", i, busy, e.busy); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_waw();
    stim_t sq[$];
    exp_t  eq[$];
    exp_t  e;
    stim_t s;
    sq.push_back(s_write(5));     eq.push_back(ex(cv(), 0, 1, 0));
    // Names r5 as a source but does not read it: must not stall.
    s = s_idle(); s.valid = 1'b1; s.rs1 = 3'd5;
    sq.push_back(s);              eq.push_back(ex(cv(5, 7), 0, 1, 1));
    sq.push_back(s_write(5));     eq.push_back(ex(cv(5, 6), 0, 1, 1));
    sq.push_back(s_read(5, 2));   eq.push_back(ex(cv(5, 7), 1, 0, 1));
    sq.push_back(s_read(5, 2));   eq.push_back(ex(cv(5, 6), 1, 0, 1));
    sq.push_back(s_read(5, 2));   eq.push_back(ex(cv(5, 5), 1, 0, 1));
    sq.push_back(s_read(5, 2));   eq.push_back(ex(cv(5, 4), 0, 1, 1));
    sq.push_back(s_idle());       eq.push_back(ex(cv(), 0, 0, 0));
    foreach (sq[i]) begin
      drive(sq[i]);
      exp_q.push_back(eq[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      checks += 4;
      if (register_invalid !== e.codes) begin errors++; $display("FAIL waw[%0d] codes: got %h expected %h", i, register_invalid, e.codes); end
      if (stall !== e.stall)            begin errors++; $display("FAIL waw[%0d] stall: got %b expected %b", i, stall, e.stall); end
      if (issue_ack !== e.ack)          begin errors++; $display("FAIL waw[%0d] issue_ack: got %b expected %b", i, issue_ack, e.ack); end
      if (busy !== e.busy)              begin errors++; $display("FAIL waw[%0d] busy: got %b expected %b", i, busy, e.busy); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_flush();
    stim_t sq[$];
    exp_t  eq[$];
    exp_t  e;
    stim_t s;
    // Flush with adv=1: r1 in slot 2 survives, r3 in slot 0 and new r4 dropped.
    sq.push_back(s_write(1));     eq.push_back(ex(cv(), 0, 1, 0));
    sq.push_back(s_idle());       eq.push_back(ex(cv(1, 7), 0, 0, 1));
    sq.push_back(s_write(3));     eq.push_back(ex(cv(1, 6), 0, 1, 1));
    s = s_write(4); s.flush = 1'b1;
    sq.push_back(s);              eq.push_back(ex(cv(1, 5, 3, 7), 0, 0, 1));
    sq.push_back(s_idle());       eq.push_back(ex(cv(1, 4), 0, 0, 1));
    sq.push_back(s_idle());       eq.push_back(ex(cv(), 0, 0, 0));
    // Flush with adv=0: r0 stays in slot 2 without moving, r6 in slot 0 dropped.
    sq.push_back(s_write(0));     eq.push_back(ex(cv(), 0, 1, 0));
    sq.push_back(s_idle());       eq.push_back(ex(cv(0, 7), 0, 0, 1));
    sq.push_back(s_write(6));     eq.push_back(ex(cv(0, 6), 0, 1, 1));
    s = s_idle(1'b0); s.flush = 1'b1;
    sq.push_back(s);              eq.push_back(ex(cv(0, 5, 6, 7), 0, 0, 1));
    sq.push_back(s_idle(1'b0));   eq.push_back(ex(cv(0, 5), 0, 0, 1));
    sq.push_back(s_idle());       eq.push_back(ex(cv(0, 5), 0, 0, 1));
    sq.push_back(s_idle());       eq.push_back(ex(cv(0, 4), 0, 0, 1));
    sq.push_back(s_idle());       eq.push_back(ex(cv(), 0, 0, 0));
    foreach (sq[i]) begin
      drive(sq[i]);
      exp_q.push_back(eq[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      checks += 4;
      if (register_invalid !== e.codes) begin errors++; $display("FAIL flush[%0d] codes: got %h expected %h", i, register_invalid, e.codes); end
      if (stall !== e.stall)            begin errors++; $display("FAIL flush[%0d] stall: got %b expected %b", i, stall, e.stall); end
      if (issue_ack !== e.ack)          begin errors++; $display("FAIL flush[%0d] issue_ack: got %b expected %b", i, issue_ack, e.ack); end
      if (busy !== e.busy)              begin errors++; $display("FAIL flush[%0d] busy: got %b expected %b", i, busy, e.busy); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_hold();
    stim_t sq[$];
    exp_t  eq[$];
    exp_t  e;
    stim_t s;
    sq.push_back(s_write(6));     eq.push_back(ex(cv(), 0, 1, 0));
    sq.push_back(s_idle());       eq.push_back(ex(cv(6, 7), 0, 0, 1));
    sq.push_back(s_idle());       eq.push_back(ex(cv(6, 6), 0, 0, 1));
    s = s_write(4); s.adv = 1'b0;
    sq.push_back(s);              eq.push_back(ex(cv(6, 5), 0, 0, 1));
    sq.push_back(s);              eq.push_back(ex(cv(6, 5), 0, 0, 1));
    // Stall still reports the hazard while the pipe is frozen.
    s.rs1 = 3'd6; s.use1 = 1'b1;
    sq.push_back(s);              eq.push_back(ex(cv(6, 5), 1, 0, 1));
    sq.push_back(s_idle());       eq.push_back(ex(cv(6, 5), 0, 0, 1));
    sq.push_back(s_idle());       eq.push_back(ex(cv(6, 4), 0, 0, 1));
    sq.push_back(s_idle());       eq.push_back(ex(cv(), 0, 0, 0));
    foreach (sq[i]) begin
      drive(sq[i]);
      exp_q.push_back(eq[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      checks += 4;
      if (register_invalid !== e.codes) begin errors++; $display("FAIL hold[%0d] codes: got %h expected %h", i, register_invalid, e.codes); end
      if (stall !== e.stall)            begin errors++; $display("FAIL hold[%0d] stall: got %b expected %b", i, stall, e.stall); end
      if (issue_ack !== e.ack)          begin errors++; $display("FAIL hold[%0d] issue_ack: got %b expected %b", i, issue_ack, e.ack); end
      if (busy !== e.busy)              begin errors++; $display("FAIL hold[%0d] busy: got %b expected %b", i, busy, e.busy); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    stim_t sq[$];
    exp_t  eq[$];
    exp_t  e;
    stim_t s;
    // Same instruction reads and writes r3: only the pre-issue state matters.
    s = s_write(3); s.rs1 = 3'd3; s.use1 = 1'b1;
    sq.push_back(s);              eq.push_back(ex(cv(), 0, 1, 0));
    sq.push_back(s_idle());       eq.push_back(ex(cv(3, 7), 0, 0, 1));
    sq.push_back(s_idle());       eq.push_back(ex(cv(3, 6), 0, 0, 1));
    sq.push_back(s_idle());       eq.push_back(ex(cv(3, 5), 0, 0, 1));
    // Retire of r3 and a fresh write to r3 in the same cycle.
    sq.push_back(s);              eq.push_back(ex(cv(3, 4), 0, 1, 1));
    sq.push_back(s_idle());       eq.push_back(ex(cv(3, 7), 0, 0, 1));
    sq.push_back(s_idle());       eq.push_back(ex(cv(3, 6), 0, 0, 1));
    sq.push_back(s_idle());       eq.push_back(ex(cv(3, 5), 0, 0, 1));
    sq.push_back(s_idle());       eq.push_back(ex(cv(3, 4), 0, 0, 1));
    sq.push_back(s_idle());       eq.push_back(ex(cv(), 0, 0, 0));
    foreach (sq[i]) begin
      drive(sq[i]);
      exp_q.push_back(eq[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      checks += 4;
      if (register_invalid !== e.codes) begin errors++; $display("FAIL b2b[%0d] codes: got %h expected %h", i, register_invalid, e.codes); end
      if (stall !== e.stall)            begin errors++; $display("FAIL b2b[%0d] stall: got %b expected %b", i, stall, e.stall); end
      if (issue_ack !== e.ack)          begin errors++; $display("FAIL b2b[%0d] issue_ack: got %b expected %b", i, issue_ack, e.ack); end
      if (busy !== e.busy)              begin errors++; $display("FAIL b2b[%0d] busy: got %b expected %b", i, busy, e.busy); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    stim_t sq[$];
    exp_t  eq[$];
    exp_t  e;
    stim_t s;
    sq.push_back(s_write(2));     eq.push_back(ex(cv(), 0, 1, 0));
    sq.push_back(s_idle());       eq.push_back(ex(cv(2, 7), 0, 0, 1));
    sq.push_back(s_write(7));     eq.push_back(ex(cv(2, 6), 0, 1, 1));
    sq.push_back(s_write(0));     eq.push_back(ex(cv(2, 5, 7, 7), 0, 1, 1));
    // r0 slot 0, r7 slot 1, r2 slot 3; reset also beats a concurrent issue to r5.
    s = s_write(5); s.reset = 1'b1;
    sq.push_back(s);              eq.push_back(ex(cv(0, 7, 7, 6, 2, 4), 0, 1, 1));
    sq.push_back(s_idle());       eq.push_back(ex(cv(), 0, 0, 0));
    sq.push_back(s_idle());       eq.push_back(ex(cv(), 0, 0, 0));
    foreach (sq[i]) begin
      drive(sq[i]);
      exp_q.push_back(eq[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      checks += 4;
      if (register_invalid !== e.codes) begin errors++; $display("FAIL reset_mid[%0d] codes: got %h expected %h", i, register_invalid, e.codes); end
      if (stall !== e.stall)            begin errors++; $display("FAIL reset_mid[%0d] stall: got %b expected %b", i, stall, e.stall); end
      if (issue_ack !== e.ack)          begin errors++; $display("FAIL reset_mid[%0d] issue_ack: got %b expected %b", i, issue_ack, e.ack); end
      if (busy !== e.busy)              begin errors++; $display("FAIL reset_mid[%0d] busy: got %b expected %b", i, busy, e.busy); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    drive(s_idle(1'b0));
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_raw();
    test_waw();
    test_flush();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
